// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for sum_accumulator: FSM encoding, default widths and the
// saturation constant.
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ACC_W  = 16;
  localparam int CNT_W          = 8;

  localparam logic [DEFAULT_ACC_W-1:0] SAT_VALUE = '1;

endpackage : sum_accumulator_pkg

// File: rtl/sum_accumulator_add_sat.sv
// Combinational accumulator adder with carry-out overflow flag.
// Clamps to all-ones on overflow when SUM_ACCUMULATOR_SATURATE_EN is defined.
module acc_add_sat #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    sum  = ovf ? '1 : full[ACC_W-1:0];
`else
    sum  = full[ACC_W-1:0];
`endif
  end

endmodule : acc_add_sat

// File: rtl/sum_accumulator.sv
// Accumulates COUNT adder results ({co, sum}) into an ACC_W-bit frame total.
// Optional saturation: define SUM_ACCUMULATOR_SATURATE_EN.
import sum_accumulator_pkg::*;

module sum_accumulator #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int COUNT  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_co,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic              out_overflow
);

  localparam logic [CNT_W-1:0] COUNT_L = CNT_W'(COUNT);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [ACC_W-1:0]   sample;
  logic [ACC_W-1:0]   add_a;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_ready     = (state_q != DONE);
  assign out_valid    = (state_q == DONE);
  assign out_total    = out_valid ? acc_q : '0;
  assign out_overflow = out_valid & ovf_q;

  assign accept  = in_valid & in_ready;
  assign sample  = ACC_W'({in_co, in_sum});
  assign cnt_inc = cnt_q + 1'b1;
  // A frame starts from zero, so the first sample goes through the adder too.
  assign add_a   = (state_q == IDLE) ? '0 : acc_q;

  acc_add_sat #(.ACC_W(ACC_W)) u_add (
    .a   (add_a),
    .b   (sample),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = add_sum;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (COUNT_L == CNT_W'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (cnt_inc == COUNT_L) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over any coincident accept or output handshake.
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : sum_accumulator

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the 8-bit adder stage.
- Accepts a stream of adder results ({co, sum}) over a valid/ready handshake and accumulates COUNT samples into a wider total.
- Presents the total to the next stage over a second valid/ready handshake.
- Runs on the clock produced by clock_gen.

Parameters:
- DATA_W, 8: width of incoming sum; incoming value is DATA_W+1 bits, i.e. {in_co, in_sum}.
- ACC_W, 16: accumulator/result width; must be at least DATA_W+1.
- COUNT, 4: samples per frame; legal range 1..255.

Ports:
- clock  input  1  rising-edge clock, shared with clock_gen.
- reset_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous frame abort; discards partial total.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  DATA_W  adder sum.
- in_co  input  1  adder carry-out.
- out_valid  output  1  frame total available.
- out_ready  input  1  downstream accepts total.
- out_total  output  ACC_W  accumulated frame total.
- out_overflow  output  1  total exceeded ACC_W during this frame.

Behaviour:
- Reset is sampled only on a rising clock edge (reset_n=0). It forces:
  - state=IDLE, acc=0, cnt=0, overflow=0
  - out_valid=0, out_total=0, out_overflow=0
  - in_ready=1 from the first cycle after reset release.
- Sample value = zero-extend({in_co, in_sum}) to ACC_W. Accept = in_valid & in_ready.
- States:
  - IDLE (in_ready=1):
    - accept → acc=value, cnt=1, overflow=0.
    - If COUNT==1 go to DONE, else ACCUM.
  - ACCUM (in_ready=1):
    - accept → acc=acc+value, cnt=cnt+1.
    - Go to DONE when new cnt==COUNT.
    - No accept → hold all state.
  - DONE (in_ready=0, out_valid=1):
    - out_total=acc, out_overflow=overflow, both held stable while out_ready=0.
    - out_valid & out_ready → go to IDLE, acc=0, cnt=0. The next sample can be accepted on the following cycle (one bubble per frame).
- Latency: out_valid rises the cycle after the COUNT-th accept.
- Arithmetic:
  - Add is performed at ACC_W+1 bits. Bit ACC_W set → overflow flag set (sticky until next frame start).
  - Default behaviour wraps modulo 2^ACC_W.
- in_valid while in DONE: the sample is not accepted; upstream must hold it.
- clear=1: next state IDLE, acc=0, cnt=0, overflow=0, out_valid=0.
  - clear overrides any simultaneous input accept or output handshake; a coincident sample is dropped.
  - in_ready stays 1 during clear so upstream is not stalled; the sample is simply discarded.
- reset_n=0 mid-frame or in DONE: same effect as clear, plus outputs return to reset values.
- Reset has priority over clear.

Optional Feature:
- Macro: SUM_ACCUMULATOR_SATURATE_EN.
- Defined: when the add result exceeds 2^ACC_W-1, acc clamps to all-ones and stays there for the rest of the frame. out_overflow still asserts.
- Undefined: acc wraps modulo 2^ACC_W, and out_overflow flags the wrap.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, ACCUM=2'd1, DONE=2'd2
  - default widths (DATA_W=8, ACC_W=16)
  - saturation constant (all-ones of ACC_W).
- One sub-module: acc_add_sat.
  - Combinational: ACC_W add with overflow output; saturating clamp selected by the macro.
- The FSM, counter and handshake stay in the top level.

Test Plan:
- Reset then basic frame (COUNT=4): feed {co,sum} = 0x005, 0x010, 0x1FF, 0x000 with in_valid always 1 and out_ready=1 → out_valid pulses one cycle after the 4th accept, out_total=0x0214, out_overflow=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → in_ready=0, out_total stable, no sample consumed. Then out_ready=1 → IDLE; the pending sample is accepted the next cycle.
- Overflow wrap (ACC_W=10, macro undefined): 4 × 0x1FF → out_total=0x3FC, out_overflow=1.
- Saturation (ACC_W=10, SUM_ACCUMULATOR_SATURATE_EN defined): 4 × 0x1FF → out_total=0x3FF, out_overflow=1.
- Clear mid-frame: accept 0x020, 0x030, then clear=1 together with in_valid=1 for 0x040 → sample dropped. The next 4 samples of 0x001 → out_total=0x004.
- Reset in DONE: drive reset_n=0 for one edge while out_valid=1 → out_valid=0, out_total=0, in_ready=1 after release. A COUNT=1 build then yields out_valid the cycle after a single accept.
